// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and default sizes for period_meter
package period_meter_pkg;
    typedef enum logic [1:0] {IDLE, MEASURE, OVERFLOW} state_t;
    localparam int NBITS_DEFAULT = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with rising-edge detect on the synchronized level
module sync_edge_det import period_meter_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level_out,
    output logic rise_out
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign level_out = sync[SYNC_STAGES-1];
    assign rise_out  = level_out & ~prev;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures sig_in period in clk cycles; PERIOD_METER_DUTY_EN adds high_out (high time)
module period_meter import period_meter_pkg::*; #(
    parameter int Nbits = NBITS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [Nbits-1:0] period_out,
    output logic             ovf_out,
    output logic             lost_out,
    output logic             meas_valid,
    input  logic             meas_ready
`ifdef PERIOD_METER_DUTY_EN
    ,
    output logic [Nbits-1:0] high_out
`endif
);
    localparam logic [Nbits-1:0] ONES = '1;
    localparam logic [Nbits-1:0] ONE = Nbits'(1);
    state_t state, state_nx;
    logic [Nbits-1:0] cnt, cnt_nx, cap_per;
    logic level, rise, cap, cap_nx, cap_ovf;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .async_in(sig_in),
        .level_out(level),
        .rise_out(rise)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        cap_nx = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx = ONE;
                end
                MEASURE: if (rise) begin
                    cap_nx = 1'b1;
                    cnt_nx = ONE;
                end else begin
                    cnt_nx = cnt + ONE;
                    state_nx = (cnt + ONE == ONES) ? OVERFLOW : MEASURE;
                end
                OVERFLOW: if (rise) begin
                    cap_nx = 1'b1;
                    cnt_nx = ONE;
                    state_nx = MEASURE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    // capture is staged one cycle so the output register loads the cycle after the edge cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            cap <= 1'b0;
            cap_per <= '0;
            cap_ovf <= 1'b0;
            period_out <= '0;
            ovf_out <= 1'b0;
            lost_out <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            cap <= cap_nx;
            if (cap_nx) begin
                cap_per <= cnt;
                cap_ovf <= (state == OVERFLOW);
            end
            if (cap) begin
                period_out <= cap_per;
                ovf_out <= cap_ovf;
                lost_out <= meas_valid & ~meas_ready;
                meas_valid <= 1'b1;
            end else if (meas_ready) begin
                meas_valid <= 1'b0;
            end
        end
    end
`ifdef PERIOD_METER_DUTY_EN
    logic [Nbits-1:0] hcnt, hcap;
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            hcap <= '0;
            high_out <= '0;
        end else begin
            hcnt <= (!en || (state == IDLE && !rise)) ? '0 :
                    rise ? ONE :
                    (state == MEASURE && level && hcnt != ONES) ? hcnt + ONE : hcnt;
            if (cap_nx) hcap <= hcnt;
            if (cap) high_out <= hcap;
        end
    end
`else
    logic unused_level;
    assign unused_level = level;
`endif
endmodule
